// File: rtl/addr_decode_mem_pkg.sv
// Shared memory-map constants, region/FSM enums and the flash request bundle.
package addr_decode_mem_pkg;

  localparam logic [31:0] BRAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] BRAM_LIMIT   = 32'h0000_FFFF;
  localparam logic [31:0] SRAM_BASE    = 32'h0001_0000;
  localparam logic [31:0] SRAM_LIMIT   = 32'h0001_FFFF;
  localparam logic [31:0] FLASH_BASE   = 32'h0002_0000;
  localparam logic [31:0] FLASH_LIMIT  = 32'h0002_0FFF;
  localparam logic [31:0] PERIPH_BASE  = 32'h0003_0000;
  localparam logic [31:0] PERIPH_LIMIT = 32'h0003_0FFF;

  localparam logic [31:0] FLASH_ERASED     = 32'hFFFF_FFFF;
  localparam int unsigned FLASH_WORDS      = 1024;
  localparam int unsigned FLASH_PAGE_WORDS = 64;
  localparam int unsigned FLASH_IDX_W      = $clog2(FLASH_WORDS);
  localparam int unsigned PAGE_OFS_W       = $clog2(FLASH_PAGE_WORDS);
  localparam int unsigned PAGE_W           = FLASH_IDX_W - PAGE_OFS_W;

  typedef enum logic [2:0] {
    REGION_NONE,
    REGION_BRAM,
    REGION_SRAM,
    REGION_FLASH,
    REGION_PERIPH
  } region_e;

  typedef enum logic [1:0] {
    FL_IDLE,
    FL_PROG,
    FL_ERASE
  } flash_state_e;

  // Flash requests arrive already qualified by region and priority.
  typedef struct packed {
    logic                   rd;
    logic                   prog;
    logic                   erase;
    logic [FLASH_IDX_W-1:0] idx;
    logic [31:0]            wdata;
  } flash_req_t;

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// Combinational address decode into a region plus decode-error flag.
// Zero latency; no flow control.
module addr_decoder
  import addr_decode_mem_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        erase_en,
  output region_e     region,
  output logic        sram_sel,
  output logic        periph_sel,
  output logic        dec_error
);

  always_comb begin
    region = REGION_NONE;
    if (in_range(addr, BRAM_BASE, BRAM_LIMIT))
      region = REGION_BRAM;
    else if (in_range(addr, SRAM_BASE, SRAM_LIMIT))
      region = REGION_SRAM;
    else if (in_range(addr, FLASH_BASE, FLASH_LIMIT))
      region = REGION_FLASH;
    else if (in_range(addr, PERIPH_BASE, PERIPH_LIMIT))
      region = REGION_PERIPH;
  end

  assign sram_sel   = (region == REGION_SRAM);
  assign periph_sel = (region == REGION_PERIPH);

  // Erase only makes sense for flash; anywhere else it is a decode error.
  assign dec_error = (rd_en || wr_en || erase_en) &&
                     ((region == REGION_NONE) ||
                      (erase_en && (region != REGION_FLASH)));

endmodule

// File: rtl/bram_core.sv
// Single-port block RAM, synchronous write and registered read.
// Read data valid one cycle after the request; never stalls.
module bram_core #(
  parameter  int unsigned WORDS = 256,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we)
      mem[idx] <= wdata;
    if (re)
      rdata <= mem[idx];
  end

endmodule

// File: rtl/flash_core.sv
// Flash model: AND-programming, per-page erase one word per cycle, busy/error flags.
// Reads return one cycle later when idle; requests while busy are dropped with an error pulse.
module flash_core
  import addr_decode_mem_pkg::*;
#(
  parameter int unsigned PROG_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  flash_req_t  req,
  output logic        busy,
  output logic        err,
  output logic        rd_fire,
  output logic [31:0] rdata
);

  localparam int unsigned CW = ($clog2(PROG_CYC) > PAGE_OFS_W) ? $clog2(PROG_CYC) : PAGE_OFS_W;

  logic [31:0] mem [FLASH_WORDS] = '{default: FLASH_ERASED};

  flash_state_e           state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PAGE_W-1:0]      page_q, page_d;
  logic                   err_d;
  logic                   prog_we, erase_we;
  logic [FLASH_IDX_W-1:0] erase_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FL_IDLE;
      cnt_q   <= '0;
      page_q  <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
    prog_we   = 1'b0;
    erase_we  = 1'b0;
    rd_fire   = 1'b0;
    erase_idx = {page_q, cnt_q[PAGE_OFS_W-1:0]};
    busy      = (state_q != FL_IDLE);
    err_d     = busy && (req.rd || req.prog || req.erase);

    unique case (state_q)
      FL_IDLE: begin
        if (req.erase) begin
          state_d = FL_ERASE;
          cnt_d   = '0;
          page_d  = req.idx[FLASH_IDX_W-1 -: PAGE_W];
        end else if (req.prog) begin
          state_d = FL_PROG;
          cnt_d   = CW'(PROG_CYC - 1);
          prog_we = 1'b1;
        end else if (req.rd) begin
          rd_fire = 1'b1;
        end
      end
      FL_PROG: begin
        if (cnt_q == '0)
          state_d = FL_IDLE;
        else
          cnt_d = cnt_q - CW'(1);
      end
      FL_ERASE: begin
        erase_we = 1'b1;
        if (cnt_q[PAGE_OFS_W-1:0] == '1)
          state_d = FL_IDLE;
        else
          cnt_d = cnt_q + CW'(1);
      end
      default: state_d = FL_IDLE;
    endcase
  end

  // Reset aborts mid-erase: the word due on the reset edge is left untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (prog_we)
        mem[req.idx] <= mem[req.idx] & req.wdata;
      else if (erase_we)
        mem[erase_idx] <= FLASH_ERASED;
    end
    if (rd_fire)
      rdata <= mem[req.idx];
  end

endmodule

// File: rtl/addr_decode_mem.sv
// Address-decoded BRAM + flash with pass-through SRAM/peripheral selects.
// rdata one cycle after a BRAM/flash read; flash requests while busy are dropped with an error pulse.
module addr_decode_mem
  import addr_decode_mem_pkg::*;
#(
  parameter int unsigned BRAM_WORDS     = 256,
  parameter int unsigned FLASH_PROG_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        erase_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sram_sel,
  output logic        periph_sel,
  output logic        flash_busy,
  output logic        error
);

  localparam int unsigned BRAM_AW = $clog2(BRAM_WORDS);

  region_e     region, sel_q, sel_d;
  logic        dec_error, flash_err, flash_rd_fire;
  logic        bram_hit, bram_we, bram_re, flash_hit;
  logic [31:0] bram_q, flash_q, hold_q;
  flash_req_t  freq;

  addr_decoder u_dec (
    .addr       (addr),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .erase_en   (erase_en),
    .region     (region),
    .sram_sel   (sram_sel),
    .periph_sel (periph_sel),
    .dec_error  (dec_error)
  );

  assign bram_hit  = (region == REGION_BRAM) && !dec_error;
  assign bram_we   = bram_hit && wr_en;
  assign bram_re   = bram_hit && rd_en && !wr_en;
  assign flash_hit = (region == REGION_FLASH);

  // Priority on flash: erase over program over read.
  always_comb begin
    freq.erase = flash_hit && erase_en;
    freq.prog  = flash_hit && wr_en && !erase_en;
    freq.rd    = flash_hit && rd_en && !wr_en && !erase_en;
    freq.idx   = addr[FLASH_IDX_W+1:2];
    freq.wdata = wdata;
  end

  bram_core #(.WORDS(BRAM_WORDS)) u_bram (
    .clk   (clk),
    .we    (bram_we),
    .re    (bram_re),
    .idx   (addr[BRAM_AW+1:2]),
    .wdata (wdata),
    .rdata (bram_q)
  );

  flash_core #(.PROG_CYC(FLASH_PROG_CYC)) u_flash (
    .clk     (clk),
    .rst     (rst),
    .req     (freq),
    .busy    (flash_busy),
    .err     (flash_err),
    .rd_fire (flash_rd_fire),
    .rdata   (flash_q)
  );

  assign sel_d = bram_re       ? REGION_BRAM  :
                 flash_rd_fire ? REGION_FLASH : REGION_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= REGION_NONE;
      hold_q <= '0;
    end else begin
      sel_q  <= sel_d;
      hold_q <= rdata;
    end
  end

  // hold_q keeps rdata stable on cycles that did not complete a read.
  always_comb begin
    case (sel_q)
      REGION_BRAM:  rdata = bram_q;
      REGION_FLASH: rdata = flash_q;
      default:      rdata = hold_q;
    endcase
  end

  assign error = dec_error | flash_err;

endmodule

// File: tb/tb_addr_decode_mem.sv
`timescale 1ns/1ps
module tb_addr_decode_mem;

  localparam int BW = 256;
  localparam int PC = 4;

  logic        clk = 1'b0;
  logic        rst, rd_en, wr_en, erase_en;
  logic [31:0] addr, wdata, rdata;
  logic        sram_sel, periph_sel, flash_busy, error;

  always #5 clk = ~clk;

  addr_decode_mem #(.BRAM_WORDS(BW), .FLASH_PROG_CYC(PC)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .erase_en(erase_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .sram_sel(sram_sel),
    .periph_sel(periph_sel), .flash_busy(flash_busy), .error(error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] bram_m  [BW];
  bit          bram_k  [BW];
  logic [31:0] flash_m [1024];
  bit          flash_k [1024];
  logic [31:0] exp_rd;
  bit          exp_rd_k;
  int          busy_left;
  bit          ferr;
  bit          m_erasing;
  int          m_page;

  // 0 none, 1 bram, 2 sram, 3 flash, 4 periph
  function automatic int region_of(input logic [31:0] a);
    if (a < 32'h0001_0000) return 1;
    if (a < 32'h0002_0000) return 2;
    if (a < 32'h0002_1000) return 3;
    if (a >= 32'h0003_0000 && a < 32'h0003_1000) return 4;
    return 0;
  endfunction

  function automatic bit model_derr();
    int r;
    r = region_of(addr);
    return (rd_en || wr_en || erase_en) && (r == 0 || (erase_en && r != 3));
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    rd_en = op[2]; wr_en = op[1]; erase_en = op[0]; addr = a; wdata = d;
  endtask

  task automatic idle();
    drive(3'b000, 32'h0, 32'h0);
  endtask

  // Advance the model by one clock, then let the DUT take the same edge.
  task automatic tick();
    int r, bi, fi;
    bit busy_now;
    if (rst) begin
      if (busy_left > 0 && m_erasing)
        for (int i = 0; i < 64; i++) flash_k[m_page*64 + i] = 1'b0;
      busy_left = 0; ferr = 1'b0; exp_rd = 32'h0; exp_rd_k = 1'b1; m_erasing = 1'b0;
    end else begin
      r  = region_of(addr);
      bi = int'((addr >> 2) % 32'(BW));
      fi = int'(((addr - 32'h0002_0000) >> 2) & 32'h3FF);
      busy_now = (busy_left > 0);
      ferr = 1'b0;
      if (busy_now) begin
        busy_left--;
        if (busy_left == 0 && m_erasing) begin
          for (int i = 0; i < 64; i++) begin
            flash_m[m_page*64 + i] = 32'hFFFF_FFFF;
            flash_k[m_page*64 + i] = 1'b1;
          end
          m_erasing = 1'b0;
        end
      end
      if ((rd_en || wr_en || erase_en) && !model_derr()) begin
        if (r == 1) begin
          if (wr_en) begin bram_m[bi] = wdata; bram_k[bi] = 1'b1; end
          else if (rd_en) begin exp_rd = bram_m[bi]; exp_rd_k = bram_k[bi]; end
        end else if (r == 3) begin
          if (busy_now) ferr = 1'b1;
          else if (erase_en) begin busy_left = 64; m_erasing = 1'b1; m_page = fi / 64; end
          else if (wr_en) begin flash_m[fi] &= wdata; busy_left = PC; end
          else begin exp_rd = flash_m[fi]; exp_rd_k = flash_k[fi]; end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); tick(); tick();
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); else n_pass++;
    n_checks++; if (flash_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", flash_busy); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_bram_rw();
    drive(3'b010, 32'h0000_0010, 32'hDEAD_BEEF); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL bram_wr_err: got %b want 0", error); else n_pass++;
    tick();
    drive(3'b100, 32'h0000_0010, 32'h0); tick();
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL bram_rd: got %h want %h", rdata, 32'hDEAD_BEEF); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL bram_rd_err: got %b want 0", error); else n_pass++;
    idle(); tick();
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL bram_hold: got %h want %h", rdata, 32'hDEAD_BEEF); else n_pass++;
  endtask

  task automatic test_decode_err();
    drive(3'b100, 32'h0005_0000, 32'h0); #1;
    n_checks++; if (error !== 1'b1) $display("FAIL dec_err: got %b want 1", error); else n_pass++;
    n_checks++; if (sram_sel !== 1'b0 || periph_sel !== 1'b0)
      $display("FAIL dec_sels: got %b%b want 00", sram_sel, periph_sel); else n_pass++;
    tick();
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL dec_rdata_hold: got %h want %h", rdata, 32'hDEAD_BEEF); else n_pass++;
    idle(); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL dec_err_clear: got %b want 0", error); else n_pass++;
  endtask

  task automatic test_flash_prog();
    int cnt;
    logic [31:0] pat [2];
    pat[0] = 32'h0F0F_0F0F; pat[1] = 32'hFFFF_00FF;
    for (int p = 0; p < 2; p++) begin
      drive(3'b010, 32'h0002_0004, pat[p]); tick(); idle();
      cnt = 0;
      for (int k = 0; k < 100 && flash_busy === 1'b1; k++) begin cnt++; tick(); end
      n_checks++; if (cnt != PC) $display("FAIL prog_busy_len[%0d]: got %0d want %0d", p, cnt, PC); else n_pass++;
    end
    drive(3'b100, 32'h0002_0004, 32'h0); tick(); idle();
    n_checks++; if (rdata !== 32'h0F0F_000F) $display("FAIL prog_read: got %h want %h", rdata, 32'h0F0F_000F); else n_pass++;
  endtask

  task automatic test_flash_erase();
    int cnt;
    drive(3'b001, 32'h0002_0000, 32'h0); tick(); idle();
    n_checks++; if (flash_busy !== 1'b1) $display("FAIL erase_busy_start: got %b want 1", flash_busy); else n_pass++;
    repeat (3) tick();
    drive(3'b100, 32'h0000_0010, 32'h0); tick(); idle();
    n_checks++; if (rdata !== 32'hDEAD_BEEF || error !== 1'b0)
      $display("FAIL bram_during_busy: got %h/%b want %h/0", rdata, error, 32'hDEAD_BEEF); else n_pass++;
    repeat (5) tick();
    drive(3'b100, 32'h0002_0004, 32'h0); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL busy_rd_same_cycle: got %b want 0", error); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (error !== 1'b1) $display("FAIL busy_err_pulse: got %b want 1", error); else n_pass++;
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL busy_rd_hold: got %h want %h", rdata, 32'hDEAD_BEEF); else n_pass++;
    tick();
    n_checks++; if (error !== 1'b0) $display("FAIL busy_err_width: got %b want 0", error); else n_pass++;
    cnt = 11;
    for (int k = 0; k < 200 && flash_busy === 1'b1; k++) begin cnt++; tick(); end
    n_checks++; if (cnt != 64) $display("FAIL erase_busy_len: got %0d want 64", cnt); else n_pass++;
    drive(3'b100, 32'h0002_0004, 32'h0); tick(); idle();
    n_checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL erase_read: got %h want %h", rdata, 32'hFFFF_FFFF); else n_pass++;
  endtask

  task automatic test_reset_mid_erase();
    int cnt;
    drive(3'b001, 32'h0002_0100, 32'h0); tick(); idle();
    repeat (19) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (flash_busy !== 1'b0) $display("FAIL rst_abort_busy: got %b want 0", flash_busy); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL rst_abort_rdata: got %h want 0", rdata); else n_pass++;
    drive(3'b001, 32'h0002_0100, 32'h0); tick(); idle();
    cnt = 0;
    for (int k = 0; k < 200 && flash_busy === 1'b1; k++) begin cnt++; tick(); end
    n_checks++; if (cnt != 64) $display("FAIL rst_reerase_len: got %0d want 64", cnt); else n_pass++;
    drive(3'b100, 32'h0002_0104, 32'h0); tick(); idle();
    n_checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL rst_reerase_read: got %h want %h", rdata, 32'hFFFF_FFFF); else n_pass++;
  endtask

  task automatic test_erase_wins();
    int cnt;
    drive(3'b010, 32'h0002_0200, 32'h0); tick(); idle();
    for (int k = 0; k < 100 && flash_busy === 1'b1; k++) tick();
    drive(3'b011, 32'h0002_0200, 32'h0); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL wr_erase_err: got %b want 0", error); else n_pass++;
    tick(); idle(); #1;
    n_checks++; if (error !== 1'b0) $display("FAIL wr_erase_pulse: got %b want 0", error); else n_pass++;
    cnt = 0;
    for (int k = 0; k < 200 && flash_busy === 1'b1; k++) begin cnt++; tick(); end
    n_checks++; if (cnt != 64) $display("FAIL wr_erase_len: got %0d want 64", cnt); else n_pass++;
    drive(3'b100, 32'h0002_0200, 32'h0); tick();
    n_checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL wr_erase_read: got %h want %h", rdata, 32'hFFFF_FFFF); else n_pass++;
    drive(3'b001, 32'h0000_0100, 32'h0); #1;
    n_checks++; if (error !== 1'b1) $display("FAIL erase_nonflash: got %b want 1", error); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_sel();
    logic [31:0] prev;
    prev = rdata;
    drive(3'b100, 32'h0001_0040, 32'h0); #1;
    n_checks++; if (sram_sel !== 1'b1 || periph_sel !== 1'b0 || error !== 1'b0)
      $display("FAIL sram_sel: got s%b p%b e%b want s1 p0 e0", sram_sel, periph_sel, error); else n_pass++;
    tick();
    n_checks++; if (rdata !== prev) $display("FAIL sram_rd_hold: got %h want %h", rdata, prev); else n_pass++;
    drive(3'b010, 32'h0003_0000, 32'h1234_5678); #1;
    n_checks++; if (sram_sel !== 1'b0 || periph_sel !== 1'b1 || error !== 1'b0)
      $display("FAIL periph_sel: got s%b p%b e%b want s0 p1 e0", sram_sel, periph_sel, error); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_boundaries();
    logic [31:0] ba [7];
    logic [2:0]  be [7];  // {error, sram_sel, periph_sel}
    ba[0] = 32'h0000_FFFC; be[0] = 3'b000;
    ba[1] = 32'h0001_FFFC; be[1] = 3'b010;
    ba[2] = 32'h0002_0FFC; be[2] = 3'b000;
    ba[3] = 32'h0002_1000; be[3] = 3'b100;
    ba[4] = 32'h0003_0FFC; be[4] = 3'b001;
    ba[5] = 32'h0003_1000; be[5] = 3'b100;
    ba[6] = 32'hFFFF_FFFC; be[6] = 3'b100;
    for (int i = 0; i < 7; i++) begin
      drive(3'b100, ba[i], 32'h0); #1;
      n_checks++; if ({error, sram_sel, periph_sel} !== be[i])
        $display("FAIL boundary %h: got %b want %b", ba[i], {error, sram_sel, periph_sel}, be[i]); else n_pass++;
      tick();
    end
    idle();
    n_checks++; if (rdata !== 32'hFFFF_FFFF) $display("FAIL flash_last_word: got %h want %h", rdata, 32'hFFFF_FFFF); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      drive(3'b010, 32'h0000_0100 + 32'(i*4), d[i]); tick();
    end
    for (int i = 3; i >= 0; i--) begin
      drive(3'b100, 32'h0000_0100 + 32'(i*4), 32'h0); tick();
      n_checks++; if (rdata !== d[i]) $display("FAIL b2b_rd[%0d]: got %h want %h", i, rdata, d[i]); else n_pass++;
    end
    // BRAM_WORDS aliasing: 0x400 lands on the same word as 0x0
    drive(3'b010, 32'h0000_0400, 32'hA5A5_5A5A); tick();
    drive(3'b100, 32'h0000_0000, 32'h0); tick(); idle();
    n_checks++; if (rdata !== 32'hA5A5_5A5A) $display("FAIL bram_alias: got %h want %h", rdata, 32'hA5A5_5A5A); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  op;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: a = 32'($urandom_range(0, 31)) << 2;
        3:       a = 32'h0000_0400 + (32'($urandom_range(0, 31)) << 2);
        4, 5:    a = 32'h0002_0000 + (32'($urandom_range(0, 15)) << 2) + 32'h100 * 32'($urandom_range(3, 4));
        6:       a = 32'h0001_0000 + 32'($urandom_range(0, 16'hFFFF));
        7:       a = 32'h0003_0000 + 32'($urandom_range(0, 12'hFFF));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8: op = 3'b100;
        9, 10, 11, 12, 13, 14, 15: op = 3'b010;
        16:                        op = 3'b001;
        17:                        op = 3'b110;
        18:                        op = 3'b000;
        default:                   op = 3'b011;
      endcase
      drive(op, a, $urandom); #1;
      n_checks++; if (error !== (model_derr() | ferr))
        $display("FAIL rnd_error @%0d addr=%h: got %b want %b", n, a, error, model_derr() | ferr); else n_pass++;
      n_checks++; if (sram_sel !== (region_of(a) == 2) || periph_sel !== (region_of(a) == 4))
        $display("FAIL rnd_sel @%0d addr=%h: got %b%b", n, a, sram_sel, periph_sel); else n_pass++;
      tick();
      n_checks++; if (flash_busy !== (busy_left > 0))
        $display("FAIL rnd_busy @%0d: got %b want %b", n, flash_busy, busy_left > 0); else n_pass++;
      if (exp_rd_k) begin
        n_checks++; if (rdata !== exp_rd) $display("FAIL rnd_rdata @%0d: got %h want %h", n, rdata, exp_rd); else n_pass++;
      end
    end
    idle();
    for (int k = 0; k < 200 && busy_left > 0; k++) tick();
    n_checks++; if (flash_busy !== 1'b0) $display("FAIL rnd_drain: got %b want 0", flash_busy); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin flash_m[i] = 32'hFFFF_FFFF; flash_k[i] = 1'b1; end
    for (int i = 0; i < BW; i++) begin bram_m[i] = 32'h0; bram_k[i] = 1'b0; end
    exp_rd = 32'h0; exp_rd_k = 1'b0; busy_left = 0; ferr = 1'b0; m_erasing = 1'b0; m_page = 0;
    rst = 1'b1; idle();
    test_reset();
    test_bram_rw();
    test_decode_err();
    test_flash_prog();
    test_flash_erase();
    test_reset_mid_erase();
    test_erase_wins();
    test_sel();
    test_boundaries();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/addr_decode_mem.md
ADDR_DECODE_MEM -- requirements
Module: addr_decode_mem

Interface
REQ-001 Parameter BRAM_WORDS, 256, BRAM depth in 32-bit words (power of 2, max 16384).
REQ-002 Parameter FLASH_PROG_CYC, 4, flash program busy duration in cycles (>=1).
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rd_en  in  1  read request, sampled each cycle.
REQ-007 wr_en  in  1  write/program request; rd_en and wr_en both high counts as a write.
REQ-008 erase_en  in  1  flash page-erase request; addr selects the page.
REQ-009 addr  in  32  byte address; bits [1:0] ignored.
REQ-010 wdata  in  32  write data.
REQ-011 rdata  out  32  read data, registered.
REQ-012 sram_sel  out  1  combinational decode of SRAM region, for external routing.
REQ-013 periph_sel  out  1  combinational decode of peripheral region, for external routing.
REQ-014 flash_busy  out  1  flash program/erase in progress.
REQ-015 error  out  1  combinational decode error OR registered flash error.

Function
REQ-016 Memory map: BRAM 0x0000_0000-0x0000_FFFF; SRAM 0x0001_0000-0x0001_FFFF; flash 0x0002_0000-0x0002_0FFF; peripheral 0x0003_0000-0x0003_0FFF; every other address is a decode error.
REQ-017 Decode error asserts error combinationally only while rd_en, wr_en or erase_en is high; an access to an unmapped address touches no storage.
REQ-018 BRAM word index = addr[15:2] modulo BRAM_WORDS; a write stores wdata at the rising edge.
REQ-019 A BRAM read returns the word on rdata one cycle after the request; a read in the cycle after a write to the same word returns the new data.
REQ-020 Flash: 1024 words, word index addr[11:2], 16 pages of 64 words, page = addr[11:8]; erased value 0xFFFF_FFFF.
REQ-021 Flash program: the stored word becomes old AND wdata, so only 1->0 bit changes; flash_busy is high for FLASH_PROG_CYC cycles starting the cycle after the request.
REQ-022 Flash erase: erase_en with a flash address sets all 64 words of that page to 0xFFFF_FFFF, one word per cycle; flash_busy is high for 64 cycles starting the cycle after the request.
REQ-023 Flash read returns the word on rdata one cycle after the request; read while idle only.
REQ-024 Any flash rd/wr/erase request while flash_busy is high is ignored; flash error pulses high for exactly the next cycle.
REQ-025 erase_en with a non-flash address is a decode error.
REQ-026 Simultaneous wr_en and erase_en to flash: erase wins, program is dropped without error.
REQ-027 rdata holds its previous value after writes, SRAM/peripheral reads and errored accesses.
REQ-028 BRAM accesses proceed normally while flash is busy.

Reset
REQ-029 rst clears rdata to 0, flash_busy to 0, flash error to 0 and aborts any program/erase in progress; the partially erased page is left as is.
REQ-030 Reset does not initialise BRAM; flash contents are 0xFFFF_FFFF at time 0 and are not changed by reset.

Structure
REQ-031 Shared package holds region base/limit constants, FLASH_ERASED (0xFFFF_FFFF), FLASH_PAGE_WORDS (64) and a region-select enum.
REQ-032 Sub-modules: addr_decoder (combinational), bram_core, flash_core with a 3-state FSM IDLE/PROG/ERASE; top muxes rdata using the registered read select.

Verification
REQ-033 Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 -> rdata 0xDEADBEEF one cycle later, error 0.
REQ-034 Read 0x0005_0000 -> error 1 in the same cycle, rdata unchanged; sram_sel and periph_sel 0.
REQ-035 Program 0x0002_0004 with 0x0F0F_0F0F then with 0xFFFF_00FF, read -> 0x0F0F_000F; flash_busy high 4 cycles each.
REQ-036 Erase page at 0x0002_0000 -> flash_busy high 64 cycles; a read issued on busy cycle 10 -> error one-cycle pulse; after busy clears, read 0x0002_0004 -> 0xFFFF_FFFF.
REQ-037 Assert rst on erase cycle 20 -> flash_busy 0 next cycle; next erase request is accepted normally.
REQ-038 Access 0x0001_0040 -> sram_sel 1; access 0x0003_0000 -> periph_sel 1; error 0 in both cases.
